// File: rtl/pe_pkg.sv
// Shared types and defaults for the single-PE sequence driver.
package pe_pkg;

  localparam int K               = 7;
  localparam int N               = 16;
  localparam int SUM_WIDTH       = 2*N + 4;
  localparam int PE_LAT_DEF      = 9;
  localparam int MAX_SAMPLES_DEF = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  typedef logic signed [N-1:0] weight_t;

  // Packs the tap weights as {w6..w0}, w0 in the low bits.
  function automatic logic [N*K-1:0] pack_weights(input weight_t w [K]);
    logic [N*K-1:0] p;
    p = '0;
    for (int i = 0; i < K; i++) begin
      p[i*N +: N] = w[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/pe_lat_tag.sv
// Tag shift line that tracks in-flight PE samples; the tag leaves exactly
// DEPTH edges after it was launched, marking when the PE result is valid.
module pe_lat_tag #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic tag_in,
  output logic tag_out
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  always_comb begin
    line_d = {line_q[DEPTH-2:0], tag_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/pe_seq_driver.sv
// Host-side driver for one PE: buffer a block, stream it through the PE,
// capture results and replay them on a valid/ready stream. PE_RELU_EN clamps
// negative results to zero on the output.
//
// state | meaning
// IDLE  | weights writable, waiting for a valid start
// LOAD  | accepting samples into the input buffer
// CLEAR | one-cycle PE reset before streaming
// RUN   | streaming samples and capturing results
// DRAIN | replaying results on the m_* stream
module pe_seq_driver
  import pe_pkg::*;
#(
  parameter  int PE_LAT      = PE_LAT_DEF,
  parameter  int MAX_SAMPLES = MAX_SAMPLES_DEF,
  localparam int CNT_W       = $clog2(MAX_SAMPLES + 1),
  localparam int ADDR_W      = $clog2(MAX_SAMPLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_idx,
  input  logic signed [N-1:0]         cfg_data,
  input  logic                        start,
  input  logic [CNT_W-1:0]            num_samples,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [N-1:0]         s_data,
  output logic                        pe_rst,
  output logic signed [N-1:0]         pe_xin,
  output logic [N*K-1:0]              pe_win,
  input  logic signed [SUM_WIDTH-1:0] pe_sum,
  input  logic signed [SUM_WIDTH-1:0] pe_sum1,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [SUM_WIDTH-1:0] m_sum,
  output logic signed [SUM_WIDTH-1:0] m_sum1,
  output logic                        busy,
  output logic                        done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      wr_q, wr_d;
  logic [CNT_W-1:0]      launch_q, launch_d;
  logic [CNT_W-1:0]      cap_q, cap_d;
  logic [CNT_W-1:0]      rd_q, rd_d;
  logic                  s_ready_q, s_ready_d;
  logic                  pe_rst_q, pe_rst_d;
  logic signed [N-1:0]   pe_xin_q, pe_xin_d;
  logic                  m_valid_q, m_valid_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  weight_t               w_q [K];
  weight_t               w_d [K];

  logic                  tag_in;
  logic                  tag_out;
  logic                  buf_we;
  logic                  res_we;

  // Buffers carry no reset; the output mux gates them with m_valid instead.
  logic signed [N-1:0]         buf_q  [MAX_SAMPLES];
  logic signed [SUM_WIDTH-1:0] sum_q  [MAX_SAMPLES];
  logic signed [SUM_WIDTH-1:0] sum1_q [MAX_SAMPLES];

  pe_lat_tag #(.DEPTH(PE_LAT)) u_lat_tag (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_d      = wr_q;
    launch_d  = launch_q;
    cap_d     = cap_q;
    rd_d      = rd_q;
    s_ready_d = 1'b0;
    pe_rst_d  = 1'b0;
    pe_xin_d  = '0;
    m_valid_d = 1'b0;
    done_d    = 1'b0;
    w_d       = w_q;
    tag_in    = 1'b0;
    buf_we    = 1'b0;
    res_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_we && cfg_idx < 3'(K)) begin
          w_d[cfg_idx] = cfg_data;
        end
        if (start && num_samples != '0 && num_samples <= MAX_CNT) begin
          count_d   = num_samples;
          wr_d      = '0;
          s_ready_d = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          buf_we = 1'b1;
          wr_d   = wr_q + ONE;
          if (wr_q == count_q - ONE) begin
            s_ready_d = 1'b0;
            pe_rst_d  = 1'b1;
            state_d   = CLEAR;
          end
        end
      end
      CLEAR: begin
        // The exit edge launches sample 0 together with its tag.
        pe_xin_d = buf_q[0];
        tag_in   = 1'b1;
        launch_d = ONE;
        cap_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        if (launch_q < count_q) begin
          pe_xin_d = buf_q[launch_q[ADDR_W-1:0]];
          tag_in   = 1'b1;
          launch_d = launch_q + ONE;
        end
        if (tag_out) begin
          res_we = 1'b1;
          cap_d  = cap_q + ONE;
          if (cap_q == count_q - ONE) begin
            rd_d      = '0;
            m_valid_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        m_valid_d = 1'b1;
        if (m_valid_q && m_ready) begin
          if (rd_q == count_q - ONE) begin
            m_valid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            rd_d = rd_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_q      <= '0;
      launch_q  <= '0;
      cap_q     <= '0;
      rd_q      <= '0;
      s_ready_q <= 1'b0;
      pe_rst_q  <= 1'b1;
      pe_xin_q  <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      w_q       <= '{default: '0};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      launch_q  <= launch_d;
      cap_q     <= cap_d;
      rd_q      <= rd_d;
      s_ready_q <= s_ready_d;
      pe_rst_q  <= pe_rst_d;
      pe_xin_q  <= pe_xin_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      w_q       <= w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_q[ADDR_W-1:0]] <= s_data;
    end
    if (res_we) begin
      sum_q[cap_q[ADDR_W-1:0]]  <= pe_sum;
      sum1_q[cap_q[ADDR_W-1:0]] <= pe_sum1;
    end
  end

  logic signed [SUM_WIDTH-1:0] sum_sel;
  logic signed [SUM_WIDTH-1:0] sum1_sel;

  assign sum_sel  = sum_q[rd_q[ADDR_W-1:0]];
  assign sum1_sel = sum1_q[rd_q[ADDR_W-1:0]];

`ifdef PE_RELU_EN
  assign m_sum  = (m_valid_q && !sum_sel[SUM_WIDTH-1])  ? sum_sel  : '0;
  assign m_sum1 = (m_valid_q && !sum1_sel[SUM_WIDTH-1]) ? sum1_sel : '0;
`else
  assign m_sum  = m_valid_q ? sum_sel  : '0;
  assign m_sum1 = m_valid_q ? sum1_sel : '0;
`endif

  assign s_ready = s_ready_q;
  assign pe_rst  = pe_rst_q;
  assign pe_xin  = pe_xin_q;
  assign pe_win  = pack_weights(w_q);
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/pe_seq_driver.md
Name: pe_seq_driver

Overview:
Host-side driver for one PE. It buffers a block of input samples, loads the 7-tap weight set onto the PE, and streams the samples into the PE contiguously, one per cycle. It captures sum/sum1 for each sample after a fixed PE latency and replays the results on a valid/ready output stream. The PE has no stall input, so streaming and capture are both fully buffered.

Parameters:
N, 16, sample/weight width (signed)
K, 7, taps per PE; fixed, width of pe_win = N*K
SUM_WIDTH, 2*N+4, PE accumulator width
PE_LAT, 9, cycles from an xin launch edge to the edge where the matching sum/sum1 is sampled
MAX_SAMPLES, 64, depth of the sample buffer and the result buffer

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  weight write strobe
cfg_idx  in  3  weight index 0..6
cfg_data  in  N  signed weight
start  in  1  begin a block (IDLE only)
num_samples  in  $clog2(MAX_SAMPLES+1)  block length, sampled on start
s_valid/s_ready  in/out  1  input sample handshake
s_data  in  N  signed input sample
pe_rst  out  1  reset to PE
pe_xin  out  N  sample to PE
pe_win  out  N*K  packed weights {w6..w0}
pe_sum, pe_sum1  in  SUM_WIDTH  PE results
m_valid/m_ready  out/in  1  result handshake
m_sum, m_sum1  out  SUM_WIDTH  result pair
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at block end

Behaviour:
- Reset values: all outputs 0, state IDLE, weights 0. pe_rst is 1 while rst is asserted, then 0.
- Weights: cfg_we writes w[cfg_idx] only in IDLE. Writes with cfg_idx>6 or while busy are ignored. pe_win is driven from the registers and is stable during a block.
- IDLE: start with num_samples in 1..MAX_SAMPLES latches the count and moves to LOAD. start with num_samples of 0 or >MAX_SAMPLES is ignored. start while busy is ignored.
- LOAD: s_ready=1. Each s_valid&s_ready writes buf[wr++]. When the last sample is accepted, s_ready drops on the next cycle and the state moves to CLEAR. Bubbles are allowed in LOAD.
- CLEAR: pe_rst=1 for exactly 1 cycle, pe_xin=0, then RUN.
- RUN: at edge j (j=0..num_samples-1), pe_xin <= buf[j] and a tag bit enters a PE_LAT-deep shift line. After the last sample, pe_xin=0 for the flush cycles. When a tag exits at edge j+PE_LAT, the current pe_sum/pe_sum1 are written to res[j]. The state moves to DRAIN on the edge that captures the last result.
- Total RUN length is num_samples+PE_LAT-1 cycles. No stall exists in RUN.
- DRAIN: m_valid=1 while rd<num_samples, with m_sum/m_sum1=res[rd]. On m_valid&m_ready, rd++. Data is held stable while m_ready=0.
- After the last transfer: done=1 for one cycle, state returns to IDLE.
- Async rst mid-block: immediate return to IDLE, buffers invalidated, m_valid=0, no done pulse.
- Pointers wrap only through reset-to-zero per block; no modular wrap within a block.

Optional Feature:
- PE_RELU_EN defined: m_sum and m_sum1 are clamped to 0 when negative (sign bit set); non-negative values pass unchanged. The clamp is applied at the DRAIN output mux and adds no latency.
- Undefined: raw signed results are output.

Decomposition:
- Package pe_pkg holds: state enum (IDLE, LOAD, CLEAR, RUN, DRAIN), localparam K=7, the default N, SUM_WIDTH and PE_LAT, and a weight-pack helper function.
- One natural sub-module, pe_lat_tag: the PE_LAT-deep tag shift register with an async clear. Sample and result buffers are inline register arrays.

Test Plan:
- The bench PE model registers sum=xin*w0 and sum1=xin*w1 through a PE_LAT delay.
- Basic block: weights w0=2, w1=-3, rest 0; num_samples=4; inputs 1,2,3,4; m_ready=1 -> sum 2,4,6,8 and sum1 -3,-6,-9,-12, in order; done pulses once after the 4th transfer.
- Output backpressure: same block with m_ready toggling every other cycle -> identical values and order, no duplicates, m_sum held while stalled.
- Input bubbles: s_valid low on alternate cycles in LOAD -> pe_xin still shows 1,2,3,4 on consecutive RUN cycles; pe_rst high exactly 1 cycle before the first sample.
- Guarding: cfg_we with w0=99 while busy, start while busy, start with num_samples=0 -> all ignored; results still use w0=2.
- Reset mid-RUN: assert rst at cycle 3 of RUN -> busy=0, m_valid=0, no done; next block of 1 sample (5) -> sum 10, sum1 -15.
- With PE_RELU_EN: inputs -1,1 with w0=2, w1=-3 -> sum 0,2 and sum1 3,0.
